// File: rtl/pio_bidir_irq.sv
// Avalon-MM PIO: per-bit direction, atomic output set/clear, synchronised pin
// reads, sticky edge capture (write-1-clear) and a maskable registered level irq.
module pio_bidir_irq #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_DIR   = '0,
  parameter int               EDGE_TYPE   = 0,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] readdata,
  inout  wire  [WIDTH-1:0] bidir_port,
  output logic             irq
);

  localparam int ARM_MAX = SYNC_STAGES + 1;
  localparam int ARM_W   = $clog2(ARM_MAX + 1);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_DIR    = 3'd1;
  localparam logic [2:0] ADDR_MASK   = 3'd2;
  localparam logic [2:0] ADDR_EDGE   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;

  logic [WIDTH-1:0]                  data_out_reg, data_out_next;
  logic [WIDTH-1:0]                  data_dir_reg, data_dir_next;
  logic [WIDTH-1:0]                  irq_mask_reg, irq_mask_next;
  logic [WIDTH-1:0]                  edge_cap_reg, edge_cap_next;
  logic [WIDTH-1:0]                  readdata_reg, readdata_next;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_reg;
  logic [WIDTH-1:0]                  s_d_reg;
  logic [ARM_W-1:0]                  arm_cnt_reg;
  logic                              irq_reg;

  logic             wr;
  logic             armed;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] edge_sel;
  logic [WIDTH-1:0] det;

  assign wr    = chipselect & ~write_n;
  assign s     = sync_reg[SYNC_STAGES-1];
  assign armed = (arm_cnt_reg == ARM_W'(ARM_MAX));
  assign det   = armed ? edge_sel : '0;

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign edge_sel = s & ~s_d_reg;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign edge_sel = ~s & s_d_reg;
    end else begin : g_any
      assign edge_sel = s ^ s_d_reg;
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_pin
      assign bidir_port[gi] = data_dir_reg[gi] ? data_out_reg[gi] : 1'bz;
    end
  endgenerate

  // A detected edge is OR-ed in after the clear, so a same-cycle set wins.
  always_comb begin
    data_out_next = data_out_reg;
    data_dir_next = data_dir_reg;
    irq_mask_next = irq_mask_reg;
    edge_cap_next = edge_cap_reg | det;
    if (wr) begin
      case (address)
        ADDR_DATA:   data_out_next = writedata;
        ADDR_DIR:    data_dir_next = writedata;
        ADDR_MASK:   irq_mask_next = writedata;
        ADDR_EDGE:   edge_cap_next = (edge_cap_reg & ~writedata) | det;
        ADDR_OUTSET: data_out_next = data_out_reg | writedata;
        ADDR_OUTCLR: data_out_next = data_out_reg & ~writedata;
        default:     ;
      endcase
    end
  end

  always_comb begin
    readdata_next = '0;
    case (address)
      ADDR_DATA:   readdata_next = s;
      ADDR_DIR:    readdata_next = data_dir_reg;
      ADDR_MASK:   readdata_next = irq_mask_reg;
      ADDR_EDGE:   readdata_next = edge_cap_reg;
      ADDR_OUTSET: readdata_next = data_out_reg;
      ADDR_OUTCLR: readdata_next = data_out_reg;
      default:     readdata_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_out_reg <= '0;
      data_dir_reg <= RESET_DIR;
      irq_mask_reg <= '0;
      edge_cap_reg <= '0;
      readdata_reg <= '0;
      sync_reg     <= '0;
      s_d_reg      <= '0;
      arm_cnt_reg  <= '0;
      irq_reg      <= 1'b0;
    end else begin
      data_out_reg <= data_out_next;
      data_dir_reg <= data_dir_next;
      irq_mask_reg <= irq_mask_next;
      edge_cap_reg <= edge_cap_next;
      readdata_reg <= readdata_next;
      sync_reg     <= {sync_reg[SYNC_STAGES-2:0], bidir_port};
      s_d_reg      <= s;
      if (!armed) arm_cnt_reg <= arm_cnt_reg + 1'b1;
      irq_reg      <= |(edge_cap_reg & irq_mask_reg);
    end
  end

  assign readdata = readdata_reg;
  assign irq      = irq_reg;

endmodule

// File: tb/tb_pio_bidir_irq.sv
// Bench for pio_bidir_irq: directed scenarios plus randomized traffic checked
// against a pin-history reference model (pins pulled up when nobody drives).
module tb_pio_bidir_irq;
  localparam int W    = 8;
  localparam int S    = 2;
  localparam int LOGN = 8192;

  logic         clk        = 1'b0;
  logic         reset_n    = 1'b0;
  logic [2:0]   address    = '0;
  logic         chipselect = 1'b0;
  logic         write_n    = 1'b1;
  logic [W-1:0] writedata  = '0;
  logic [W-1:0] readdata;
  logic         irq;
  wire  [W-1:0] pins;
  logic [W-1:0] tb_en  = '0;
  logic [W-1:0] tb_val = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < W; gi++) begin : g_pin
    assign pins[gi] = tb_en[gi] ? tb_val[gi] : 1'bz;
    pullup pu (pins[gi]);
  end

  pio_bidir_irq #(
    .WIDTH(W), .RESET_DIR(8'h00), .EDGE_TYPE(0), .SYNC_STAGES(S)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .bidir_port(pins), .irq(irq)
  );

  // Reference model: remembers what every pin looked like at every edge and
  // applies the register rules directly to that history.
  logic [W-1:0] m_out = '0, m_dir = '0, m_mask = '0, m_edge = '0, m_rd = '0;
  logic         m_irq = 1'b0;
  logic [W-1:0] pin_log [LOGN];
  int unsigned  g = 0, rst_g = 0;

  function automatic logic [W-1:0] exp_pins();
    return (m_dir & m_out) | (~m_dir & (tb_val | ~tb_en));
  endfunction

  always @(posedge clk) begin : mdl
    int unsigned  m;
    logic [W-1:0] cur, prev, det, clr;
    logic         wr;
    m   = g - rst_g;
    cur = '0; prev = '0; det = '0; clr = '0;
    wr  = chipselect && !write_n;
    pin_log[g % LOGN] <= exp_pins();
    g <= g + 1;
    if (!reset_n) begin
      rst_g <= g;
      m_out <= '0; m_dir <= '0; m_mask <= '0; m_edge <= '0; m_rd <= '0; m_irq <= 1'b0;
    end else begin
      if (m >= S + 1) cur = pin_log[(g - S) % LOGN];
      if (m >= S + 2) begin
        prev = pin_log[(g - S - 1) % LOGN];
        det  = cur & ~prev;
      end
      case (address)
        3'd0: m_rd <= cur;
        3'd1: m_rd <= m_dir;
        3'd2: m_rd <= m_mask;
        3'd3: m_rd <= m_edge;
        3'd4, 3'd5: m_rd <= m_out;
        default: m_rd <= '0;
      endcase
      m_irq <= |(m_edge & m_mask);
      if (wr && address == 3'd3) clr = writedata;
      m_edge <= (m_edge & ~clr) | det;
      if (wr) begin
        case (address)
          3'd0: m_out <= writedata;
          3'd1: m_dir <= writedata;
          3'd2: m_mask <= writedata;
          3'd4: m_out <= m_out | writedata;
          3'd5: m_out <= m_out & ~writedata;
          default: ;
        endcase
      end
    end
  end

  task automatic do_write(input logic [2:0] a, input logic [W-1:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    $display("wr addr=%0d data=%02h", a, d);
  endtask

  task automatic do_read(input logic [2:0] a, output logic [W-1:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk);
    d = readdata;
    chipselect = 1'b0;
    $display("rd addr=%0d data=%02h", a, d);
  endtask

  task automatic test_reset();
    logic [W-1:0] d;
    reset_n = 1'b0; tb_en = '0;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
    n_checks++; if (readdata !== 8'h00) begin n_fail++; $display("FAIL reset_readdata: got %02h expected 00", readdata); end
    n_checks++; if (pins !== 8'hFF) begin n_fail++; $display("FAIL reset_pins_z: got %02h expected FF (undriven)", pins); end
    do_read(3'd1, d);
    n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL reset_dir: got %02h expected 00", d); end
    do_read(3'd3, d);
    n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL reset_edge: got %02h expected 00", d); end
    do_read(3'd2, d);
    n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL reset_mask: got %02h expected 00", d); end
  endtask

  task automatic test_outputs();
    logic [W-1:0] d, exp;
    tb_en = '0;
    do_write(3'd1, 8'hFF);
    do_write(3'd0, 8'hA5);
    do_write(3'd4, 8'h0A);
    do_write(3'd5, 8'h81);
    exp = (8'hA5 | 8'h0A) & ~8'h81;
    n_checks++; if (pins !== exp) begin n_fail++; $display("FAIL out_pins: got %02h expected %02h", pins, exp); end
    repeat (S) @(negedge clk);
    do_read(3'd0, d);
    n_checks++; if (d !== exp) begin n_fail++; $display("FAIL out_data_readback: got %02h expected %02h", d, exp); end
    do_read(3'd4, d);
    n_checks++; if (d !== exp) begin n_fail++; $display("FAIL out_outset_read: got %02h expected %02h", d, exp); end
    do_read(3'd6, d);
    n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL out_addr6_read: got %02h expected 00", d); end
  endtask

  task automatic test_edge_irq();
    logic [W-1:0] d;
    do_write(3'd1, 8'h00);
    tb_en = 8'hFF; tb_val = 8'h00;
    repeat (S + 2) @(negedge clk);
    do_write(3'd3, 8'hFF);
    do_write(3'd2, 8'h01);
    @(negedge clk);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL edge_irq_idle: got %b expected 0", irq); end
    tb_val = 8'h01;
    for (int k = 1; k <= S + 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (irq !== (k == S + 2)) begin
        n_fail++; $display("FAIL edge_irq_latency: cycle %0d got %b expected %b", k, irq, (k == S + 2));
      end
    end
    do_read(3'd3, d);
    n_checks++; if (d !== 8'h01) begin n_fail++; $display("FAIL edge_cap_bit0: got %02h expected 01", d); end
    do_write(3'd3, 8'h01);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL edge_irq_hold: got %b expected 1", irq); end
    @(negedge clk);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL edge_irq_clear: got %b expected 0", irq); end
  endtask

  task automatic test_set_wins();
    logic [W-1:0] d;
    tb_val = 8'h09;
    repeat (S) @(negedge clk);
    do_write(3'd3, 8'h08);
    do_read(3'd3, d);
    n_checks++; if (d !== 8'h08) begin n_fail++; $display("FAIL set_wins_edge: got %02h expected 08", d); end
  endtask

  task automatic test_reset_high_pins();
    logic [W-1:0] d;
    tb_en = 8'hFF; tb_val = 8'hFF;
    reset_n = 1'b0;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    do_write(3'd2, 8'hFF);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL high_pins_irq: cycle %0d got %b expected 0", k, irq); end
    end
    do_read(3'd3, d);
    n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL high_pins_edge: got %02h expected 00", d); end
  endtask

  task automatic test_reset_midop();
    logic [W-1:0] d;
    tb_en = '0;
    do_write(3'd2, 8'hFF);
    do_write(3'd1, 8'hFF);
    do_write(3'd0, 8'h5A);
    repeat (S + 2) @(negedge clk);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL midop_irq_before: got %b expected 1", irq); end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL midop_irq_after: got %b expected 0", irq); end
    n_checks++; if (pins !== 8'hFF) begin n_fail++; $display("FAIL midop_pins_z: got %02h expected FF (undriven)", pins); end
    n_checks++; if (readdata !== 8'h00) begin n_fail++; $display("FAIL midop_readdata: got %02h expected 00", readdata); end
    for (int a = 1; a <= 4; a++) begin
      do_read(3'(a), d);
      n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL midop_reg%0d: got %02h expected 00", a, d); end
    end
  endtask

  task automatic test_random(input int n);
    logic [W-1:0] want, ok;
    want = '0;
    for (int c = 0; c < n; c++) begin
      ok = ~(m_dir & tb_en);
      n_checks++; if (readdata !== m_rd) begin n_fail++; $display("FAIL rand_readdata: cycle %0d got %02h expected %02h", c, readdata, m_rd); end
      n_checks++; if (irq !== m_irq) begin n_fail++; $display("FAIL rand_irq: cycle %0d got %b expected %b", c, irq, m_irq); end
      n_checks++; if ((pins & ok) !== (exp_pins() & ok)) begin n_fail++; $display("FAIL rand_pins: cycle %0d got %02h expected %02h", c, pins & ok, exp_pins() & ok); end
      reset_n    = ($urandom_range(0, 99) != 0);
      address    = 3'($urandom_range(0, 7));
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 2) == 0);
      writedata  = W'($urandom);
      if (c % 3 == 0) begin
        want   = W'($urandom);
        tb_val = W'($urandom);
      end
      tb_en = want & ~m_dir;
      @(negedge clk);
    end
    chipselect = 1'b0; write_n = 1'b1; reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_outputs();
    test_edge_irq();
    test_set_wins();
    test_reset_high_pins();
    test_reset_midop();
    test_random(1500);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
